// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed SDF FFT output frames into natural frequency order.
// Ping-pong frame banks: one bank fills while the other drains.
module fft_bitrev_reorder #(
  parameter int MAX_LOG_N = 10,
  parameter int WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [2:0]           di_mode_sel,
  input  logic                 di_en,
  input  logic [WIDTH-1:0]     di_re,
  input  logic [WIDTH-1:0]     di_im,
  output logic                 do_en,
  output logic [WIDTH-1:0]     do_re,
  output logic [WIDTH-1:0]     do_im,
  output logic [MAX_LOG_N-1:0] do_idx,
  output logic                 do_last,
  output logic                 do_abort
);

  localparam int              AW       = MAX_LOG_N;
  localparam int              DEPTH    = 1 << MAX_LOG_N;
  localparam logic [3:0]      MAX_LN   = 4'(MAX_LOG_N);
  localparam logic [AW-1:0]   CNT_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]   CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL  = 1'b1} wr_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DRAIN = 1'b1} rd_state_t;

  function automatic logic [3:0] mode_to_log_n(input logic [2:0] mode);
    logic [3:0] ln_s;
    case (mode)
      3'd0:    ln_s = 4'd5;
      3'd1:    ln_s = 4'd6;
      3'd2:    ln_s = 4'd7;
      3'd3:    ln_s = 4'd8;
      3'd4:    ln_s = 4'd9;
      default: ln_s = 4'd10;
    endcase
    if (ln_s > MAX_LN) begin
      ln_s = MAX_LN;
    end else begin
      ln_s = ln_s;
    end
    return ln_s;
  endfunction

  function automatic logic [AW-1:0] last_cnt_f(input logic [3:0] ln);
    logic [AW:0] span_s;
    span_s = {{AW{1'b0}}, 1'b1} << ln;
    span_s = span_s - {{AW{1'b0}}, 1'b1};
    return span_s[AW-1:0];
  endfunction

  // Full-width reversal, then shift down so only the low ln bits are reversed.
  function automatic logic [AW-1:0] bitrev_f(input logic [AW-1:0] v, input logic [3:0] ln);
    logic [AW-1:0] rev_s;
    logic [3:0]    sh_s;
    for (int i = 0; i < AW; i++) begin
      rev_s[i] = v[AW-1-i];
    end
    sh_s = MAX_LN - ln;
    return rev_s >> sh_s;
  endfunction

  wr_state_t          wr_state_r, wr_state_nxt_s;
  logic [AW-1:0]      wr_cnt_r, wr_cnt_nxt_s;
  logic [3:0]         wr_log_n_r, wr_log_n_nxt_s;
  logic               wr_bank_r, wr_bank_nxt_s;
  logic               we_s;
  logic [AW-1:0]      waddr_s;
  logic               bank_full_s;
  logic               abort_s;

  logic               bank_full_r;
  logic               full_bank_r;
  logic [3:0]         full_log_n_r;

  rd_state_t          rd_state_r, rd_state_nxt_s;
  logic [AW-1:0]      rd_cnt_r, rd_cnt_nxt_s;
  logic               rd_bank_r, rd_bank_nxt_s;
  logic [3:0]         rd_log_n_r, rd_log_n_nxt_s;
  logic               pend_r, pend_nxt_s;
  logic               rd_fire_s;
  logic               rd_last_s;
  logic               avail_s;

  logic [2*WIDTH-1:0] mem_r [0:2*DEPTH-1];
  logic [2*WIDTH-1:0] rd_word_s;

  // Write FSM next-state: scatter samples to bit-reversed addresses.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    wr_cnt_nxt_s   = wr_cnt_r;
    wr_log_n_nxt_s = wr_log_n_r;
    wr_bank_nxt_s  = wr_bank_r;
    we_s           = 1'b0;
    waddr_s        = CNT_ZERO;
    bank_full_s    = 1'b0;
    abort_s        = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (di_en) begin
          we_s           = 1'b1;
          wr_log_n_nxt_s = mode_to_log_n(di_mode_sel);
          wr_cnt_nxt_s   = CNT_ONE;
          wr_state_nxt_s = W_FILL;
        end else begin
          wr_cnt_nxt_s   = CNT_ZERO;
        end
      end
      W_FILL: begin
        if (di_en) begin
          we_s    = 1'b1;
          waddr_s = bitrev_f(wr_cnt_r, wr_log_n_r);
          if (wr_cnt_r == last_cnt_f(wr_log_n_r)) begin
            bank_full_s    = 1'b1;
            wr_bank_nxt_s  = ~wr_bank_r;
            wr_cnt_nxt_s   = CNT_ZERO;
            wr_state_nxt_s = W_IDLE;
          end else begin
            wr_cnt_nxt_s   = wr_cnt_r + CNT_ONE;
          end
        end else begin
          // Partial frame: drop it and reuse the same bank.
          abort_s        = 1'b1;
          wr_cnt_nxt_s   = CNT_ZERO;
          wr_state_nxt_s = W_IDLE;
        end
      end
      default: begin
        wr_state_nxt_s = W_IDLE;
        wr_cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Write FSM state and completed-frame handoff registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_state_r   <= W_IDLE;
      wr_cnt_r     <= CNT_ZERO;
      wr_log_n_r   <= 4'd5;
      wr_bank_r    <= 1'b0;
      bank_full_r  <= 1'b0;
      full_bank_r  <= 1'b0;
      full_log_n_r <= 4'd5;
    end else begin
      wr_state_r   <= wr_state_nxt_s;
      wr_cnt_r     <= wr_cnt_nxt_s;
      wr_log_n_r   <= wr_log_n_nxt_s;
      wr_bank_r    <= wr_bank_nxt_s;
      bank_full_r  <= bank_full_s;
      if (bank_full_s) begin
        full_bank_r  <= wr_bank_r;
        full_log_n_r <= wr_log_n_r;
      end
    end
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (reset_n && we_s) begin
      mem_r[{wr_bank_r, waddr_s}] <= {di_re, di_im};
    end
  end

  assign rd_last_s = (rd_cnt_r == last_cnt_f(rd_log_n_r));
  assign avail_s   = bank_full_r | pend_r;
  assign rd_word_s = mem_r[{rd_bank_r, rd_cnt_r}];

  // Read FSM next-state: linear drain, chaining straight into a waiting frame.
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    rd_cnt_nxt_s   = rd_cnt_r;
    rd_bank_nxt_s  = rd_bank_r;
    rd_log_n_nxt_s = rd_log_n_r;
    pend_nxt_s     = pend_r | bank_full_r;
    rd_fire_s      = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (avail_s) begin
          rd_state_nxt_s = R_DRAIN;
          rd_cnt_nxt_s   = CNT_ZERO;
          rd_bank_nxt_s  = full_bank_r;
          rd_log_n_nxt_s = full_log_n_r;
          pend_nxt_s     = 1'b0;
        end else begin
          rd_cnt_nxt_s   = CNT_ZERO;
        end
      end
      R_DRAIN: begin
        rd_fire_s = 1'b1;
        if (rd_last_s) begin
          rd_cnt_nxt_s = CNT_ZERO;
          if (avail_s) begin
            rd_bank_nxt_s  = full_bank_r;
            rd_log_n_nxt_s = full_log_n_r;
            pend_nxt_s     = 1'b0;
          end else begin
            rd_state_nxt_s = R_IDLE;
          end
        end else begin
          rd_cnt_nxt_s = rd_cnt_r + CNT_ONE;
        end
      end
      default: begin
        rd_state_nxt_s = R_IDLE;
        rd_cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Read FSM state registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_state_r <= R_IDLE;
      rd_cnt_r   <= CNT_ZERO;
      rd_bank_r  <= 1'b0;
      rd_log_n_r <= 4'd5;
      pend_r     <= 1'b0;
    end else begin
      rd_state_r <= rd_state_nxt_s;
      rd_cnt_r   <= rd_cnt_nxt_s;
      rd_bank_r  <= rd_bank_nxt_s;
      rd_log_n_r <= rd_log_n_nxt_s;
      pend_r     <= pend_nxt_s;
    end
  end

  // Registered outputs; sample data holds while do_en is low.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      do_en    <= 1'b0;
      do_re    <= {WIDTH{1'b0}};
      do_im    <= {WIDTH{1'b0}};
      do_idx   <= CNT_ZERO;
      do_last  <= 1'b0;
      do_abort <= 1'b0;
    end else begin
      do_en    <= rd_fire_s;
      do_abort <= abort_s;
      if (rd_fire_s) begin
        do_re   <= rd_word_s[2*WIDTH-1:WIDTH];
        do_im   <= rd_word_s[WIDTH-1:0];
        do_idx  <= rd_cnt_r;
        do_last <= rd_last_s;
      end else begin
        do_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: inputs in bit-reversed order carry
// value offset+k at position bitrev(k), so natural output k must read offset+k.
module tb_fft_bitrev_reorder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  di_mode_sel = 3'd0;
  logic        di_en = 1'b0;
  logic [15:0] di_re = 16'd0;
  logic [15:0] di_im = 16'd0;
  logic        do_en;
  logic [15:0] do_re;
  logic [15:0] do_im;
  logic [9:0]  do_idx;
  logic        do_last;
  logic        do_abort;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_in_edge = 0;

  int          q_idx[$];
  logic [15:0] q_re[$];
  logic [15:0] q_im[$];
  logic        q_last[$];
  int          rise_cyc[$];
  int          abort_cnt = 0;
  logic        prev_en = 1'b0;

  fft_bitrev_reorder #(.MAX_LOG_N(10), .WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .di_mode_sel(di_mode_sel), .di_en(di_en),
    .di_re(di_re), .di_im(di_im), .do_en(do_en), .do_re(do_re), .do_im(do_im),
    .do_idx(do_idx), .do_last(do_last), .do_abort(do_abort)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Output recorder, sampled on the falling edge.
  always @(negedge clock) begin
    if (do_en === 1'b1) begin
      q_idx.push_back(int'(do_idx));
      q_re.push_back(do_re);
      q_im.push_back(do_im);
      q_last.push_back(do_last);
      if (prev_en !== 1'b1) rise_cyc.push_back(cyc);
    end
    if (do_abort === 1'b1) abort_cnt++;
    prev_en = (do_en === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int tb_bitrev(int v, int ln);
    int r = 0;
    for (int i = 0; i < ln; i++) if (v[i]) r = r | (1 << (ln - 1 - i));
    return r;
  endfunction

  function automatic int find_bad(int base, int n, int offset);
    logic [15:0] exp_re;
    for (int k = 0; k < n; k++) begin
      if (base + k >= q_idx.size()) return k;
      exp_re = 16'(offset + k);
      if (q_idx[base+k] != k || q_re[base+k] !== exp_re ||
          q_im[base+k] !== (exp_re ^ 16'h5A5A) || q_last[base+k] !== (k == n - 1))
        return k;
    end
    return -1;
  endfunction

  function automatic int got_idx(int pos);
    return (pos >= 0 && pos < q_idx.size()) ? q_idx[pos] : -1;
  endfunction

  function automatic int got_re(int pos);
    return (pos >= 0 && pos < q_re.size()) ? int'(q_re[pos]) : -1;
  endfunction

  function automatic int count_last(int base);
    int c = 0;
    for (int i = base; i < q_last.size(); i++) if (q_last[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic send_samples(input logic [2:0] mode_first, input logic [2:0] mode_rest,
                              input int ln, input int count, input int offset);
    for (int p = 0; p < count; p++) begin
      @(negedge clock);
      if (p == 0) first_in_edge = cyc + 1;
      di_en       = 1'b1;
      di_mode_sel = (p == 0) ? mode_first : mode_rest;
      di_re       = 16'(offset + tb_bitrev(p, ln));
      di_im       = di_re ^ 16'h5A5A;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clock);
      di_en = 1'b0;
    end
  endtask

  task automatic wait_outputs(input int base, input int n, input int limit);
    for (int t = 0; t < limit && (q_idx.size() - base) < n; t++) @(negedge clock);
    idle(20);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle(3);
    checks++; if (do_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b, expected 0", do_en); end
    checks++; if (do_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, expected 0", do_last); end
    checks++; if (do_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b, expected 0", do_abort); end
    checks++; if (do_idx !== 10'd0) begin errors++; $display("FAIL reset_idx: got %0d, expected 0", do_idx); end
    checks++; if (do_re !== 16'd0 || do_im !== 16'd0) begin errors++; $display("FAIL reset_data: got re=%h im=%h, expected 0", do_re, do_im); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_n32;
    int base = q_idx.size(); int rb = rise_cyc.size(); int bad;
    send_samples(3'd0, 3'd3, 5, 32, 0);
    idle(1);
    wait_outputs(base, 32, 200);
    checks++; if (q_idx.size() - base != 32) begin errors++; $display("FAIL n32_count: got %0d, expected 32", q_idx.size() - base); end
    bad = find_bad(base, 32, 0);
    checks++; if (bad != -1) begin errors++; $display("FAIL n32_data: entry %0d got idx=%0d re=%h, expected idx=%0d re=%h", bad, got_idx(base+bad), got_re(base+bad), bad, bad); end
    checks++; if (rise_cyc.size() - rb != 1) begin errors++; $display("FAIL n32_contig: got %0d do_en bursts, expected 1", rise_cyc.size() - rb); end
    checks++; if (rise_cyc.size() > rb && rise_cyc[rb] - first_in_edge != 33) begin errors++; $display("FAIL n32_latency: got %0d, expected 33", rise_cyc[rb] - first_in_edge); end
    checks++; if (count_last(base) != 1) begin errors++; $display("FAIL n32_last: got %0d, expected 1", count_last(base)); end
  endtask

  task automatic test_back_to_back;
    int base = q_idx.size(); int rb = rise_cyc.size(); int bad;
    for (int f = 0; f < 3; f++) send_samples(3'd5, 3'd5, 10, 1024, f * 16'h1000);
    idle(1);
    wait_outputs(base, 3072, 3400);
    checks++; if (q_idx.size() - base != 3072) begin errors++; $display("FAIL b2b_count: got %0d, expected 3072", q_idx.size() - base); end
    checks++; if (rise_cyc.size() - rb != 1) begin errors++; $display("FAIL b2b_contig: got %0d do_en bursts, expected 1", rise_cyc.size() - rb); end
    checks++; if (count_last(base) != 3) begin errors++; $display("FAIL b2b_last: got %0d, expected 3", count_last(base)); end
    for (int f = 0; f < 3; f++) begin
      bad = find_bad(base + f * 1024, 1024, f * 16'h1000);
      checks++; if (bad != -1) begin errors++; $display("FAIL b2b_data%0d: entry %0d got idx=%0d re=%h, expected idx=%0d re=%h", f, bad, got_idx(base+f*1024+bad), got_re(base+f*1024+bad), bad, f*16'h1000+bad); end
    end
  endtask

  task automatic test_abort;
    int base = q_idx.size(); int ab = abort_cnt; int bad;
    send_samples(3'd1, 3'd1, 6, 40, 16'h7000);
    idle(1);
    send_samples(3'd1, 3'd1, 6, 64, 16'h4000);
    idle(1);
    wait_outputs(base, 64, 300);
    checks++; if (abort_cnt - ab != 1) begin errors++; $display("FAIL abort_pulse: got %0d pulse cycles, expected 1", abort_cnt - ab); end
    checks++; if (q_idx.size() - base != 64) begin errors++; $display("FAIL abort_count: got %0d, expected 64", q_idx.size() - base); end
    bad = find_bad(base, 64, 16'h4000);
    checks++; if (bad != -1) begin errors++; $display("FAIL abort_data: entry %0d got idx=%0d re=%h, expected idx=%0d re=%h", bad, got_idx(base+bad), got_re(base+bad), bad, 16'h4000+bad); end
  endtask

  task automatic test_mode_switch;
    int base = q_idx.size(); int bad;
    send_samples(3'd2, 3'd2, 7, 128, 16'h1000);
    send_samples(3'd0, 3'd0, 5, 32, 16'h2000);
    idle(1);
    wait_outputs(base, 160, 400);
    checks++; if (q_idx.size() - base != 160) begin errors++; $display("FAIL switch_count: got %0d, expected 160", q_idx.size() - base); end
    bad = find_bad(base, 128, 16'h1000);
    checks++; if (bad != -1) begin errors++; $display("FAIL switch_data128: entry %0d got idx=%0d re=%h, expected idx=%0d re=%h", bad, got_idx(base+bad), got_re(base+bad), bad, 16'h1000+bad); end
    bad = find_bad(base + 128, 32, 16'h2000);
    checks++; if (bad != -1) begin errors++; $display("FAIL switch_data32: entry %0d got idx=%0d re=%h, expected idx=%0d re=%h", bad, got_idx(base+128+bad), got_re(base+128+bad), bad, 16'h2000+bad); end
    checks++; if (count_last(base) != 2) begin errors++; $display("FAIL switch_last: got %0d, expected 2", count_last(base)); end
  endtask

  task automatic test_reset_mid_drain;
    int base = q_idx.size(); int got = 0; int base2; int bad;
    send_samples(3'd0, 3'd0, 5, 32, 16'h3000);
    idle(1);
    for (int t = 0; t < 200 && got < 10; t++) begin
      @(negedge clock); #1;
      got = q_idx.size() - base;
    end
    reset_n = 1'b0;
    @(negedge clock);
    checks++; if (do_en !== 1'b0) begin errors++; $display("FAIL rst_drain_en: got %b, expected 0", do_en); end
    reset_n = 1'b1;
    idle(60);
    checks++; if (q_idx.size() - base != 10) begin errors++; $display("FAIL rst_drain_count: got %0d, expected 10", q_idx.size() - base); end
    base2 = q_idx.size();
    send_samples(3'd0, 3'd0, 5, 32, 16'h3800);
    idle(1);
    wait_outputs(base2, 32, 200);
    checks++; if (q_idx.size() - base2 != 32) begin errors++; $display("FAIL rst_next_count: got %0d, expected 32", q_idx.size() - base2); end
    bad = find_bad(base2, 32, 16'h3800);
    checks++; if (bad != -1) begin errors++; $display("FAIL rst_next_data: entry %0d got idx=%0d re=%h, expected idx=%0d re=%h", bad, got_idx(base2+bad), got_re(base2+bad), bad, 16'h3800+bad); end
  endtask

  task automatic test_mode7;
    int base = q_idx.size(); int bad;
    send_samples(3'd7, 3'd7, 10, 1024, 16'h0800);
    idle(1);
    wait_outputs(base, 1024, 1200);
    checks++; if (q_idx.size() - base != 1024) begin errors++; $display("FAIL mode7_count: got %0d, expected 1024", q_idx.size() - base); end
    checks++; if (got_idx(base + 1023) != 1023) begin errors++; $display("FAIL mode7_maxidx: got %0d, expected 1023", got_idx(base + 1023)); end
    bad = find_bad(base, 1024, 16'h0800);
    checks++; if (bad != -1) begin errors++; $display("FAIL mode7_data: entry %0d got idx=%0d re=%h, expected idx=%0d re=%h", bad, got_idx(base+bad), got_re(base+bad), bad, 16'h0800+bad); end
  endtask

  initial begin
    test_reset;
    test_n32;
    test_back_to_back;
    test_abort;
    test_mode_switch;
    test_reset_mid_drain;
    test_mode7;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Output reorder stage placed directly after the last SDF FFT unit. It converts each bit-reversed FFT output frame into natural frequency order. It uses a ping-pong pair of frame buffers, so the write of frame k+1 overlaps the read of frame k. The point size is runtime-selectable from 32 to 1024 and uses the same mode encoding as the FFT stages.

Parameters:
MAX_LOG_N, 10, log2 of the largest supported FFT size; each bank holds 2^MAX_LOG_N words.
WIDTH, 16, bit width of each real/imag component.

Ports:
clock  input  1  master clock; all logic is rising-edge.
reset_n  input  1  synchronous, active-low reset.
di_mode_sel  input  3  point size: 0=32, 1=64, 2=128, 3=256, 4=512, 5=1024; 6 and 7 are treated as 1024.
di_en  input  1  input sample valid; high for N contiguous cycles per frame.
di_re  input  WIDTH  input sample, real part (bit-reversed order).
di_im  input  WIDTH  input sample, imag part.
do_en  output  1  output sample valid.
do_re  output  WIDTH  output sample, real part (natural order).
do_im  output  WIDTH  output sample, imag part.
do_idx  output  10  natural bin index of the current output sample.
do_last  output  1  high with the final sample (do_idx = N-1) of a frame.
do_abort  output  1  one-cycle pulse when a partial input frame is discarded.

Behaviour:
- Reset: sampled only on a clock edge with reset_n=0.
  - Output values: do_en=0, do_last=0, do_abort=0, do_idx=0, do_re/do_im=0.
  - Internal state: both FSMs go to IDLE, write bank select = 0.
  - Buffer RAM contents are not cleared.
  - Reset mid-frame or mid-drain discards all buffered data.
- Frame size: log_n = 5 + di_mode_sel (clamped to 10); N = 2^log_n.
  - The mode is latched on the first di_en cycle of a frame.
  - A mode change mid-frame is ignored until the next frame.
- Write FSM, states IDLE and FILL:
  - IDLE -> FILL on di_en=1. That sample is written at wr_cnt=0; wr_cnt is 10 bits.
  - Each di_en cycle writes the sample to the write bank at addr = bitrev(wr_cnt[log_n-1:0]) over log_n bits. Upper address bits are 0.
  - When wr_cnt = N-1 is written: bank_full pulses, the write bank select toggles, wr_cnt returns to 0, and the FSM goes to IDLE.
  - Back-to-back frames are allowed: di_en staying high goes straight into a new FILL on the other bank with no gap.
  - If di_en drops while in FILL with wr_cnt < N: the partial frame is dropped, do_abort pulses on the next cycle, wr_cnt returns to 0, the FSM goes to IDLE, and the bank select is NOT toggled.
- Read FSM, states IDLE and DRAIN:
  - bank_full moves it to DRAIN on the bank just completed, using that frame's latched log_n.
  - rd_cnt runs 0..N-1, one per cycle, reading addr = rd_cnt.
  - The RAM read is registered, so the do_* outputs follow the address by 1 cycle.
  - do_idx = rd_cnt delayed by one cycle. do_last = (do_idx == N-1) && do_en.
  - After rd_cnt = N-1 the FSM returns to IDLE. If bank_full arrives in that same cycle it goes directly to DRAIN on the other bank, so do_en has no gap.
  - do_re/do_im hold their last value when do_en=0.
- Latency: the last input sample is captured at edge c; do_en is high for the N cycles following edge c+2.
  - First output appears N+1 cycles after the first input.
  - Throughput is 1 sample/clock sustained.
- Overrun cannot occur: with contiguous input, the read of bank A (N cycles) always completes before bank B fills. No backpressure port exists.
- Data path is a pure copy: no scaling, rounding or sign changes.

Test Plan:
- N=32 (mode 0): input value k presented at input position bitrev5(k), for k=0..31 -> do_re = do_idx = 0..31 in order, do_last at idx 31, do_en exactly 32 cycles, first do_en 33 cycles after the first di_en.
- Mode 5 (1024): three frames back-to-back with no gaps -> 3072 contiguous do_en cycles in natural order per frame, do_last high exactly 3 times.
- Mode 1 (64): di_en drops after 40 samples, then a full frame follows -> one do_abort pulse, no do_en for the partial frame, and the full frame is output correctly from the bank it started in.
- Frame in mode 2 (128) followed immediately by a frame in mode 0 (32) -> 128 outputs with do_idx up to 127, then 32 outputs with do_idx up to 31, and no corruption across the mode switch.
- reset_n=0 for one cycle at output sample 10 of a drain -> do_en=0 on the next cycle, no further outputs from that frame, and the next input frame is output correctly.
- di_mode_sel=7 -> behaves as 1024-point, do_idx reaches 1023.
